// File: rtl/fwd_hazard_if.sv
// Execute-stage operand bus between the decode/execute register, the
// forwarding/hazard unit and the ALU.
interface fwd_hazard_if #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int CNT_W      = 32
);
    logic                       in_valid;
    logic [REG_AW-1:0]          in_rs1;
    logic [REG_AW-1:0]          in_rs2;
    logic [XLEN-1:0]            in_rs1_data;
    logic [XLEN-1:0]            in_rs2_data;
    logic [XLEN-1:0]            in_pc;
    logic [XLEN-1:0]            in_imm;
    logic [XLEN-1:0]            in_shamt;
    logic                       pc_reg1_sel;
    logic [1:0]                 imm_rs2_shamt_sel;
    logic [REG_AW-1:0]          in_rd;
    logic                       in_reg_write;
    logic                       in_is_load;
    logic                       flush;
    logic [FWD_STAGES*XLEN-1:0] stage_data;
    logic [XLEN-1:0]            op_a;
    logic [XLEN-1:0]            op_b;
    logic [XLEN-1:0]            store_data;
    logic                       stall;
    logic                       out_valid;
    logic [CNT_W-1:0]           stall_count;
    logic [CNT_W-1:0]           fwd_count;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_pc,
               in_imm, in_shamt, pc_reg1_sel, imm_rs2_shamt_sel, in_rd,
               in_reg_write, in_is_load, flush, stage_data,
        input  op_a, op_b, store_data, stall, out_valid, stall_count, fwd_count
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_pc,
               in_imm, in_shamt, pc_reg1_sel, imm_rs2_shamt_sel, in_rd,
               in_reg_write, in_is_load, flush, stage_data,
        output op_a, op_b, store_data, stall, out_valid, stall_count, fwd_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Execute-stage operand forwarding and load-use hazard detection with an
// internal tag pipeline covering FWD_STAGES downstream stages.
module fwd_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic        clock,
    input  logic        reset,
    fwd_hazard_if.slave io
);
    logic [FWD_STAGES-1:0] tag_v;
    logic [FWD_STAGES-1:0] tag_wr;
    logic [FWD_STAGES-1:0] tag_ld;
    logic [REG_AW-1:0]     tag_rd [FWD_STAGES];

    logic [XLEN-1:0] fv1, fv2;
    logic            hit1, hit2, haz1, haz2;
    logic            stall_int, issue, fwd_used;

    // Scan oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        fv1  = io.in_rs1_data;
        fv2  = io.in_rs2_data;
        hit1 = 1'b0;
        hit2 = 1'b0;
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (tag_v[i] && tag_wr[i] && (tag_rd[i] == io.in_rs1) && (io.in_rs1 != '0)) begin
                fv1  = io.stage_data[i*XLEN +: XLEN];
                hit1 = 1'b1;
                haz1 = tag_ld[i] && (i < LOAD_LAT);
            end
            if (tag_v[i] && tag_wr[i] && (tag_rd[i] == io.in_rs2) && (io.in_rs2 != '0)) begin
                fv2  = io.stage_data[i*XLEN +: XLEN];
                hit2 = 1'b1;
                haz2 = tag_ld[i] && (i < LOAD_LAT);
            end
        end
    end

    // rs2 always counts as used because the store-data path reads it.
    assign stall_int = io.in_valid && !io.flush && ((!io.pc_reg1_sel && haz1) || haz2);
    assign issue     = io.in_valid && !io.flush && !stall_int;
    assign fwd_used  = (!io.pc_reg1_sel && hit1) || hit2;

    assign io.op_a       = io.pc_reg1_sel ? io.in_pc : fv1;
    assign io.op_b       = io.imm_rs2_shamt_sel[1] ? io.in_imm :
                           io.imm_rs2_shamt_sel[0] ? io.in_shamt : fv2;
    assign io.store_data = fv2;
    assign io.stall      = stall_int;
    assign io.out_valid  = issue;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_v  <= '0;
            tag_wr <= '0;
            tag_ld <= '0;
            for (int i = 0; i < FWD_STAGES; i++) tag_rd[i] <= '0;
            io.stall_count <= '0;
            io.fwd_count   <= '0;
        end else begin
            tag_v[0]  <= issue;
            tag_rd[0] <= io.in_rd;
            tag_wr[0] <= io.in_reg_write;
            tag_ld[0] <= io.in_is_load;
            for (int i = 1; i < FWD_STAGES; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_rd[i] <= tag_rd[i-1];
                tag_wr[i] <= tag_wr[i-1];
                tag_ld[i] <= tag_ld[i-1];
            end
            if (stall_int && (io.stall_count != '1))
                io.stall_count <= io.stall_count + 1'b1;
            if (issue && fwd_used && (io.fwd_count != '1))
                io.fwd_count <= io.fwd_count + 1'b1;
        end
    end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised execute-stage operand forwarding and load-use hazard unit; successor to the fixed two-source execute bypass mux.
- Keeps an internal tag pipeline of in-flight destination registers for FWD_STAGES downstream stages, selects the youngest matching result for each operand, and stalls on load-use hazards.
- Sits between the decode/execute pipeline register and the ALU; drives ALU operand A/B and the store-data operand.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width
FWD_STAGES, 2, downstream stages able to forward (index 0 = memory, 1 = write-back, ...); range 1..4
LOAD_LAT, 1, lowest stage index at which load data is valid; range 0..FWD_STAGES-1
CNT_W, 32, performance counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
in_valid  in  1  instruction present in execute
in_rs1  in  REG_AW  source 1 address
in_rs2  in  REG_AW  source 2 address
in_rs1_data  in  XLEN  register file rs1 value
in_rs2_data  in  XLEN  register file rs2 value
in_pc  in  XLEN  instruction PC
in_imm  in  XLEN  immediate
in_shamt  in  XLEN  shift amount (zero-extended)
pc_reg1_sel  in  1  1: operand A = in_pc
imm_rs2_shamt_sel  in  2  1x: B = imm; 01: B = shamt; 00: B = forwarded rs2
in_rd  in  REG_AW  destination of the execute instruction
in_reg_write  in  1  execute instruction writes rd
in_is_load  in  1  execute instruction is a load
flush  in  1  kill the execute instruction (branch redirect)
stage_data  in  FWD_STAGES*XLEN  result of stage i at bits [i*XLEN +: XLEN]
op_a  out  XLEN  ALU operand A
op_b  out  XLEN  ALU operand B
store_data  out  XLEN  forwarded rs2 value, independent of imm_rs2_shamt_sel
stall  out  1  hold fetch/decode/execute this cycle
out_valid  out  1  execute result valid (issued to memory stage)
stall_count  out  CNT_W  cycles with stall = 1
fwd_count  out  CNT_W  issued instructions using at least one forwarded operand

Behaviour:
- Tag entry i = {v, rd, wr, ld}. Reset (reset = 0, async): all v = 0, counters = 0. With no valid entries, op_a/op_b/store_data equal the register-file or select values; stall = 0; out_valid = in_valid & ~flush.
- Match(src, i) = v_i & wr_i & (rd_i == src) & (src != 0). x0 never forwards; it reads in_rs*_data.
- Forwarded value fv(src) = stage_data[i] for the lowest matching i (youngest wins); otherwise the register-file value.
- op_a = pc_reg1_sel ? in_pc : fv(rs1). op_b follows imm_rs2_shamt_sel (10/11 imm, 01 shamt, 00 fv(rs2)). store_data = fv(rs2) always. All are combinational, with no added latency.
- Load-use hazard: the lowest matching i for rs1 (when pc_reg1_sel = 0) or rs2 (when sel = 00, or any sel when the store path is used; treat rs2 as always used) has ld_i = 1 and i < LOAD_LAT. Then stall = in_valid & ~flush & hazard.
- out_valid = in_valid & ~flush & ~stall.
- On each rising edge: entry 0 <= {out_valid, in_rd, in_reg_write, in_is_load}; entry i <= entry i-1 for i >= 1. A stall inserts a bubble into entry 0 while older entries keep advancing, so a hazard resolves after exactly LOAD_LAT - i cycles.
- flush and stall asserted together: flush wins, stall = 0, bubble inserted.
- stall_count += 1 each cycle stall = 1. fwd_count += 1 when out_valid and any operand takes a stage_data value. Both counters saturate at all-ones and never wrap.
- reset asserted mid-stall: stall drops immediately (entries cleared asynchronously).
- LOAD_LAT = 0: stall is never asserted.

Test Plan:
- Reset, no entries; rs1=3, rs2=4, data 0x11/0x22, sel=00 -> op_a=0x11, op_b=0x22, stall=0.
- Issue add rd=5 (wr=1). Next cycle rs1=5, stage_data[0]=0xAAAA -> op_a=0xAAAA. Cycle after (entry 1), stage_data[1]=0xBBBB -> op_a=0xBBBB.
- rd=5 in both entry 0 and entry 1 with stage_data 0x1/0x2 -> op_a=0x1 (youngest wins). rd=0 writer with rs1=0 -> register-file value.
- Load rd=7 issued, next instruction rs2=7, LOAD_LAT=1 -> stall=1 for exactly 1 cycle, out_valid=0, stall_count=1. Then op_b=stage_data[1] and fwd_count increments.
- Load-use stall with flush=1 in the same cycle -> stall=0, out_valid=0, entry 0 bubble. Also assert reset during a stall -> stall=0 asynchronously and counters=0.
- sel=01/shamt=3, rs2 matching entry 0 -> op_b=3, store_data=stage_data[0]. Preload the counter to near max over 2^CNT_W-1 stalls (CNT_W=4 build) -> holds at 15.
